// File: rtl/spi_shift_register_pkg.sv
// Shared definitions for the SPI serialiser: FSM state encoding, default frame width
// and the strobe-set selector also used by the baud rate generator.
package spi_shift_register_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } spi_state_e;

    // Modes 1 and 2 use the "high" strobe pair, modes 0 and 3 the "low" pair.
    function automatic logic spi_strobe_sel(input logic cpha, input logic cpol);
        return cpha ^ cpol;
    endfunction

endpackage

// File: rtl/spi_shift_register_if.sv
// Bundle of control, strobe and pin signals between the APB/baud side and the
// SPI shift register.
interface spi_shift_register_if #(
    parameter int DATA_WIDTH = spi_shift_register_pkg::SPI_DATA_WIDTH
);
    logic                  ss;
    logic                  send_data;
    logic                  lsbfe;
    logic                  cpha;
    logic                  cpol;
    logic                  flag_low;
    logic                  flags_low;
    logic                  flag_high;
    logic                  flags_high;
    logic [DATA_WIDTH-1:0] data_mosi;
    logic                  miso;
    logic                  mosi;
    logic [DATA_WIDTH-1:0] data_miso;
    logic                  receive_data;
    logic                  busy;

    modport master (
        output ss, send_data, lsbfe, cpha, cpol,
        output flag_low, flags_low, flag_high, flags_high,
        output data_mosi, miso,
        input  mosi, data_miso, receive_data, busy
    );

    modport slave (
        input  ss, send_data, lsbfe, cpha, cpol,
        input  flag_low, flags_low, flag_high, flags_high,
        input  data_mosi, miso,
        output mosi, data_miso, receive_data, busy
    );

endinterface

// File: rtl/spi_shift_register_bit_counter.sv
// Bit index counter for one direction of an SPI frame; clear wins over load,
// load wins over increment.
module spi_bit_counter #(
    parameter int WIDTH    = 4,
    parameter int TC_VALUE = 7
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == WIDTH'(TC_VALUE));

endmodule

// File: rtl/spi_shift_register.sv
// SPI serialiser/deserialiser: shifts a latched TX word out on mosi and assembles
// the RX word from miso using the baud generator's edge strobes.
module spi_shift_register
    import spi_shift_register_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input logic                 PCLK,
    input logic                 PRESETn,
    spi_shift_register_if.slave bus
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam int CW = IW + 1;

    spi_state_e            state;
    spi_state_e            state_next;
    logic                  sel;
    logic                  tx_stb;
    logic                  rx_stb;
    logic                  start;
    logic                  abort;
    logic                  tx_inc;
    logic                  rx_inc;
    logic [CW-1:0]         tx_idx;
    logic [CW-1:0]         rx_idx;
    logic                  tx_tc;
    logic                  rx_tc;
    logic [DATA_WIDTH-1:0] tx_shadow;
    logic [DATA_WIDTH-1:0] rx_shadow;
    logic [DATA_WIDTH-1:0] rx_next;
    logic                  lsb_q;

    // Maps a frame position to a word bit according to the bit order.
    function automatic logic [IW-1:0] bit_pos(input logic [CW-1:0] idx, input logic lsb_first);
        logic [CW-1:0] p;
        p = lsb_first ? idx : (CW'(DATA_WIDTH - 1) - idx);
        return p[IW-1:0];
    endfunction

    assign sel    = spi_strobe_sel(bus.cpha, bus.cpol);
    assign tx_stb = sel ? bus.flags_high : bus.flags_low;
    assign rx_stb = sel ? bus.flag_high  : bus.flag_low;
    assign start  = (state == IDLE) && bus.send_data && !bus.ss;
    assign abort  = (state == XFER) && bus.ss;
    assign tx_inc = (state == XFER) && !bus.ss && tx_stb && !tx_tc;
    assign rx_inc = (state == XFER) && !bus.ss && rx_stb;

    spi_bit_counter #(
        .WIDTH   (CW),
        .TC_VALUE(DATA_WIDTH - 1)
    ) u_tx_counter (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (abort),
        .load    (start),
        .load_val('0),
        .inc     (tx_inc),
        .count   (tx_idx),
        .tc      (tx_tc)
    );

    spi_bit_counter #(
        .WIDTH   (CW),
        .TC_VALUE(DATA_WIDTH - 1)
    ) u_rx_counter (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (abort),
        .load    (start),
        .load_val('0),
        .inc     (rx_inc),
        .count   (rx_idx),
        .tc      (rx_tc)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = XFER;
            XFER: begin
                if (bus.ss) begin
                    state_next = IDLE;
                end else if (rx_stb && rx_tc) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state == XFER);
        bus.receive_data = (state == DONE);
    end

    always_comb begin
        rx_next = rx_shadow;
        rx_next[bit_pos(rx_idx, lsb_q)] = bus.miso;
    end

    // data_miso takes the word including the final bit on the last rx strobe,
    // so it is already valid during the one-cycle receive_data pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bus.mosi      <= 1'b0;
            bus.data_miso <= '0;
            tx_shadow     <= '0;
            rx_shadow     <= '0;
            lsb_q         <= 1'b0;
        end else if (start) begin
            tx_shadow <= bus.data_mosi;
            lsb_q     <= bus.lsbfe;
            rx_shadow <= '0;
            bus.mosi  <= bus.data_mosi[bit_pos('0, bus.lsbfe)];
        end else if (abort) begin
            bus.mosi <= 1'b0;
        end else begin
            if (tx_inc) begin
                bus.mosi <= tx_shadow[bit_pos(tx_idx + 1'b1, lsb_q)];
            end
            if (rx_inc) begin
                rx_shadow <= rx_next;
                if (rx_tc) begin
                    bus.data_miso <= rx_next;
                end
            end
        end
    end

endmodule
